prco_mem_arbiter: RTL
=====================

Name: prco_mem_arbiter

Overview:
- Single-port arbiter and sequencer for the core's shared local memory (prco_lmem).
- Two requesters share the memory: instruction fetch (read-only) and the ALU data path (load/store).
- One transaction is outstanding at a time. Data access has priority; a starvation guard guarantees fetch progress.
- Replaces the ad-hoc address muxing and clock-enable delay registers in prco_core with an explicit FSM and req/ack handshake.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LATENCY, 1, cycles from address presented to valid read data; legal range 1..7.
- FETCH_STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_fetch_req  in  1  fetch request; level, held until ack.
- i_fetch_addr  in  ADDR_W  fetch address (pc).
- q_fetch_ack  out  1  one-cycle pulse; q_rdata valid for fetch.
- i_data_req  in  1  data request; level, held until ack.
- i_data_we  in  1  1 = store, 0 = load.
- i_data_addr  in  ADDR_W  data address (ALU result).
- i_data_wdata  in  DATA_W  store data.
- q_data_ack  out  1  one-cycle pulse; load data valid / store done.
- q_rdata  out  DATA_W  captured read data; held until the next ack.
- q_mem_addr  out  ADDR_W  memory address, registered.
- q_mem_we  out  1  memory write enable, registered.
- q_mem_dina  out  DATA_W  memory write data, registered.
- i_mem_douta  in  DATA_W  memory read data.
- q_busy  out  1  transaction in flight.
- q_stat_fetch  out  16  fetch grant count (see Optional Feature).
- q_stat_data  out  16  data grant count.
- q_stat_stall  out  16  cycles with a request pending and not granted.

Behaviour:
- Reset (async): state S_IDLE. All outputs 0. Latency counter 0. Starvation counter 0.
- An in-flight transaction is abandoned: no ack, and q_mem_we drops immediately.
- FSM states: S_IDLE, S_BUSY, S_RESP.
- S_IDLE, no request pending: hold q_mem_addr, q_mem_we = 0, q_busy = 0.
- S_IDLE, request pending: arbitrate at edge T.
  - Register owner, q_mem_addr, and q_mem_dina (= i_data_wdata for a data owner).
  - q_mem_we = i_data_we only when data wins.
  - Load latency counter with MEM_LATENCY. Go to S_BUSY. q_busy = 1 from T.
- S_BUSY:
  - q_mem_we is cleared at the first edge, so a store writes exactly one cycle.
  - Counter decrements each cycle. At 0, go to S_RESP.
- S_RESP:
  - Capture i_mem_douta into q_rdata; writes leave q_rdata unchanged.
  - Pulse the owner's ack for exactly one cycle. Return to S_IDLE.
  - Ack is high in cycle T + MEM_LATENCY + 1.
- Throughput: one transaction per MEM_LATENCY + 2 cycles.
  - A request may be re-arbitrated in the cycle after its ack.
  - The requester must drop or update req in the ack cycle, or it is re-granted.
- Arbitration:
  - Both requesting, starvation counter < FETCH_STARVE_MAX: data wins, counter increments.
  - Both requesting, counter = FETCH_STARVE_MAX: fetch wins.
  - Any fetch grant clears the counter.
  - Fetch alone always wins; data alone always wins.
- Request dropped mid-transaction is illegal. The transaction completes and acks anyway; a store still writes.
- Address, we, and wdata are sampled only at the grant edge. Later changes are ignored.
- Both acks high in the same cycle must never occur (assertion).

Optional Feature:
- Macro: PRCO_ARB_STATS_EN.
- Defined: q_stat_fetch and q_stat_data increment on each grant. q_stat_stall increments each cycle a req is high without that requester owning the memory. All three saturate at 16'hFFFF and clear on reset.
- Undefined: the three stat ports are tied to 0 and the counters are not synthesised.

Decomposition:
- Shared constants include (alongside the existing prco constants):
  - state encodings PRCO_ARB_S_IDLE / S_BUSY / S_RESP;
  - owner codes PRCO_ARB_OWN_FETCH / OWN_DATA.
- One sub-module: prco_sat_counter (WIDTH param; inc and clr inputs; saturating output). Used for the starvation counter and the three stats counters.

Test Plan:
- Fetch only, addr 0x0010, memory returns 0xBEEF, MEM_LATENCY = 1 -> q_mem_addr = 0x0010 at T; q_fetch_ack and q_rdata = 0xBEEF at T+2; q_mem_we never high.
- Data store addr 0x0040, wdata 0x1234 -> q_mem_we high exactly one cycle with q_mem_dina = 0x1234; q_data_ack at T+2; q_rdata unchanged.
- Both requests held continuously, FETCH_STARVE_MAX = 4 -> grant order D,D,D,D,F,D,D,D,D,F; no cycle with both acks high.
- MEM_LATENCY = 3, data load -> ack at T+4; q_busy high from T through T+4.
- Assert i_reset while in S_BUSY on a store -> q_mem_we = 0 immediately, no ack, state S_IDLE, fresh fetch completes normally afterward.
- With PRCO_ARB_STATS_EN: 3 fetch + 2 data grants, with fetch held 4 waiting cycles -> q_stat_fetch = 3, q_stat_data = 2, q_stat_stall = 4. Without the macro, all stat ports read 0.

Source files
------------

// File: rtl/prco_mem_arbiter_pkg.sv
// prco_mem_arbiter_pkg
//   Shared constants for the prco core's local-memory arbiter: default bus
//   widths, arbiter FSM state encodings, owner codes and the fixed-priority
//   pick with starvation override.
package prco_mem_arbiter_pkg;

    // Core-wide bus widths
    localparam int unsigned PRCO_ADDR_W = 16;
    localparam int unsigned PRCO_DATA_W = 16;

    // Statistics counter width
    localparam int unsigned PRCO_ARB_STAT_W = 16;

    typedef enum logic [1:0] {
        PRCO_ARB_S_IDLE = 2'd0,
        PRCO_ARB_S_BUSY = 2'd1,
        PRCO_ARB_S_RESP = 2'd2
    } prco_arb_state_e;

    typedef enum logic {
        PRCO_ARB_OWN_FETCH = 1'b0,
        PRCO_ARB_OWN_DATA  = 1'b1
    } prco_arb_owner_e;

    // Data has priority unless fetch has lost often enough to be forced through.
    // Only meaningful when at least one request is present.
    function automatic prco_arb_owner_e prco_arb_pick(input logic fetch_req,
                                                      input logic data_req,
                                                      input logic starve_full);
        prco_arb_owner_e owner;
        owner = PRCO_ARB_OWN_DATA;
        if (fetch_req && (!data_req || starve_full)) begin
            owner = PRCO_ARB_OWN_FETCH;
        end
        return owner;
    endfunction

endpackage

// File: rtl/prco_sat_counter.sv
// prco_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping. Clear has
//   priority over increment.
//   Ports:
//     i_clk    clock, posedge
//     i_reset  asynchronous active-high reset, clears the count
//     i_clr    synchronous clear
//     i_inc    increment request
//     q_count  current count
module prco_sat_counter
    import prco_mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = PRCO_ARB_STAT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] q_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q_count = count_q;

endmodule

// File: rtl/prco_mem_arbiter.sv
// prco_mem_arbiter
//   Single-port arbiter/sequencer for the shared local memory. Instruction
//   fetch (read-only) and the ALU data path (load/store) request with a
//   level req held until a one-cycle ack. One transaction is in flight at a
//   time; data wins ties unless fetch has lost FETCH_STARVE_MAX times in a
//   row. Ack arrives MEM_LATENCY + 1 cycles after the grant edge, and the
//   edge closing the ack cycle can grant the next transaction.
//
//   Optional build macro PRCO_ARB_STATS_EN: enables the saturating grant and
//   stall statistics counters; when undefined the stat ports read 0.
//
//   Ports:
//     i_clk, i_reset                clock / async active-high reset
//     i_fetch_req, i_fetch_addr     fetch request and pc
//     q_fetch_ack                   fetch done, q_rdata valid
//     i_data_req, i_data_we,        data request, store select,
//     i_data_addr, i_data_wdata     address and store data
//     q_data_ack                    load data valid / store done
//     q_rdata                       last captured read data
//     q_mem_addr, q_mem_we,         registered memory address, write enable
//     q_mem_dina, i_mem_douta       and write data; memory read data
//     q_busy                        transaction in flight
//     q_stat_fetch, q_stat_data,    grant counts and stalled-request cycles
//     q_stat_stall
module prco_mem_arbiter
    import prco_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W           = PRCO_ADDR_W,
    parameter int unsigned DATA_W           = PRCO_DATA_W,
    parameter int unsigned MEM_LATENCY      = 1,
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_fetch_req,
    input  logic [ADDR_W-1:0]          i_fetch_addr,
    output logic                       q_fetch_ack,
    input  logic                       i_data_req,
    input  logic                       i_data_we,
    input  logic [ADDR_W-1:0]          i_data_addr,
    input  logic [DATA_W-1:0]          i_data_wdata,
    output logic                       q_data_ack,
    output logic [DATA_W-1:0]          q_rdata,
    output logic [ADDR_W-1:0]          q_mem_addr,
    output logic                       q_mem_we,
    output logic [DATA_W-1:0]          q_mem_dina,
    input  logic [DATA_W-1:0]          i_mem_douta,
    output logic                       q_busy,
    output logic [PRCO_ARB_STAT_W-1:0] q_stat_fetch,
    output logic [PRCO_ARB_STAT_W-1:0] q_stat_data,
    output logic [PRCO_ARB_STAT_W-1:0] q_stat_stall
);

    localparam int unsigned LAT_W    = 3;  // MEM_LATENCY <= 7
    localparam int unsigned STARVE_W = 4;  // FETCH_STARVE_MAX <= 15

    prco_arb_state_e   state_q, state_d;
    prco_arb_owner_e   owner_q, owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fetch_ack_q, fetch_ack_d;
    logic              data_ack_q, data_ack_d;

    // Arbitration
    logic                arb_open;
    logic                grant;
    logic                grant_fetch;
    logic                grant_data;
    logic                starve_full;
    logic                starve_inc;
    logic                starve_clr;
    logic [STARVE_W-1:0] starve_cnt;
    prco_arb_owner_e     winner;

    // The ack cycle (S_RESP) arbitrates too, so back-to-back transactions
    // take MEM_LATENCY + 2 cycles each.
    assign arb_open    = (state_q == PRCO_ARB_S_IDLE) || (state_q == PRCO_ARB_S_RESP);
    assign starve_full = (starve_cnt >= STARVE_W'(FETCH_STARVE_MAX));
    assign winner      = prco_arb_pick(i_fetch_req, i_data_req, starve_full);
    assign grant       = arb_open && (i_fetch_req || i_data_req);
    assign grant_fetch = grant && (winner == PRCO_ARB_OWN_FETCH);
    assign grant_data  = grant && (winner == PRCO_ARB_OWN_DATA);

    // Only a contested data win counts as a fetch loss.
    assign starve_inc  = grant_data && i_fetch_req;
    assign starve_clr  = grant_fetch;

    prco_sat_counter #(
        .WIDTH (STARVE_W)
    ) u_starve (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (starve_clr),
        .i_inc   (starve_inc),
        .q_count (starve_cnt)
    );

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        store_d     = store_q;
        addr_d      = addr_q;
        we_d        = 1'b0;  // a store drives we for the grant cycle only
        dina_d      = dina_q;
        rdata_d     = rdata_q;
        fetch_ack_d = 1'b0;
        data_ack_d  = 1'b0;

        case (state_q)
            PRCO_ARB_S_IDLE, PRCO_ARB_S_RESP: begin
                state_d = PRCO_ARB_S_IDLE;
                if (grant) begin
                    state_d = PRCO_ARB_S_BUSY;
                    lat_d   = LAT_W'(MEM_LATENCY);
                    if (grant_data) begin
                        owner_d = PRCO_ARB_OWN_DATA;
                        addr_d  = i_data_addr;
                        dina_d  = i_data_wdata;
                        we_d    = i_data_we;
                        store_d = i_data_we;
                    end else begin
                        owner_d = PRCO_ARB_OWN_FETCH;
                        addr_d  = i_fetch_addr;
                        store_d = 1'b0;
                    end
                end
            end

            PRCO_ARB_S_BUSY: begin
                if (lat_q == '0) begin
                    // Read data has been valid for this cycle; register it
                    // together with the ack so both appear in S_RESP.
                    state_d = PRCO_ARB_S_RESP;
                    if (!store_q) begin
                        rdata_d = i_mem_douta;
                    end
                    fetch_ack_d = (owner_q == PRCO_ARB_OWN_FETCH);
                    data_ack_d  = (owner_q == PRCO_ARB_OWN_DATA);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            default: begin
                state_d = PRCO_ARB_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= PRCO_ARB_S_IDLE;
            owner_q     <= PRCO_ARB_OWN_FETCH;
            lat_q       <= '0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            dina_q      <= '0;
            rdata_q     <= '0;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            store_q     <= store_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            dina_q      <= dina_d;
            rdata_q     <= rdata_d;
            fetch_ack_q <= fetch_ack_d;
            data_ack_q  <= data_ack_d;
        end
    end

    assign q_fetch_ack = fetch_ack_q;
    assign q_data_ack  = data_ack_q;
    assign q_rdata     = rdata_q;
    assign q_mem_addr  = addr_q;
    assign q_mem_we    = we_q;
    assign q_mem_dina  = dina_q;
    assign q_busy      = (state_q != PRCO_ARB_S_IDLE);

`ifdef PRCO_ARB_STATS_EN
    logic fetch_owned;
    logic data_owned;
    logic stall_inc;

    assign fetch_owned = q_busy && (owner_q == PRCO_ARB_OWN_FETCH);
    assign data_owned  = q_busy && (owner_q == PRCO_ARB_OWN_DATA);
    // One count per cycle even if both requesters are waiting.
    assign stall_inc   = (i_fetch_req && !fetch_owned && !grant_fetch) ||
                         (i_data_req && !data_owned && !grant_data);

    prco_sat_counter #(
        .WIDTH (PRCO_ARB_STAT_W)
    ) u_stat_fetch (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (grant_fetch),
        .q_count (q_stat_fetch)
    );

    prco_sat_counter #(
        .WIDTH (PRCO_ARB_STAT_W)
    ) u_stat_data (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (grant_data),
        .q_count (q_stat_data)
    );

    prco_sat_counter #(
        .WIDTH (PRCO_ARB_STAT_W)
    ) u_stat_stall (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (stall_inc),
        .q_count (q_stat_stall)
    );
`else
    assign q_stat_fetch = '0;
    assign q_stat_data  = '0;
    assign q_stat_stall = '0;
`endif

    // Only one owner exists, so two acks together means corrupted state.
    assert property (@(posedge i_clk) disable iff (i_reset) !(q_fetch_ack && q_data_ack));

endmodule
